// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: op encodings, FSM states and datapath widths.
package alu_pkg;

  localparam int unsigned DataW = 4;
  localparam int unsigned ProdW = 8;

  typedef enum logic [2:0] {
    OpNegA = 3'b000,
    OpNegB = 3'b001,
    OpAdd  = 3'b010,
    OpSub  = 3'b011,
    OpAnd  = 3'b100,
    OpOr   = 3'b101,
    OpMul  = 3'b110,
    OpRsvd = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StMul,
    StDone
  } state_e;

endpackage

// File: rtl/alu4_add.sv
// 4-bit ripple adder with carry-in; the only adder in the ALU datapath.
module alu4_add
  import alu_pkg::*;
(
  input  logic [DataW-1:0] a,
  input  logic [DataW-1:0] b,
  input  logic             cin,
  output logic [DataW-1:0] sum,
  output logic             cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{DataW{1'b0}}, cin};

endmodule

// File: rtl/alu_seq_ctrl.sv
// Sequential ALU with valid/ready handshakes; MUL is a 4-step shift-add through the shared adder.
module alu_seq_ctrl
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [DataW-1:0] a,
  input  logic [DataW-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ProdW-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             err,
  output logic             busy
);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [DataW-1:0] mcand_q, mcand_d;
  logic [DataW-1:0] acc_q, acc_d;
  // mq also carries operand b for the single-cycle ops.
  logic [DataW-1:0] mq_q, mq_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [ProdW-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic             err_q, err_d;
  logic             out_valid_q, out_valid_d;

  logic [DataW-1:0] add_x, add_y, add_sum, mul_sel;
  logic             add_cin, add_cout, mul_c;

  alu4_add u_add (
    .a    (add_x),
    .b    (add_y),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_comb begin
    add_x   = '0;
    add_y   = '0;
    add_cin = 1'b0;
    if (state_q == StMul) begin
      add_x = acc_q;
      add_y = mcand_q;
    end else begin
      unique case (op_q)
        OpNegA:  begin add_y = ~mcand_q; add_cin = 1'b1; end
        OpNegB:  begin add_y = ~mq_q;    add_cin = 1'b1; end
        OpAdd:   begin add_x = mcand_q;  add_y = mq_q; end
        OpSub:   begin add_x = mcand_q;  add_y = ~mq_q; add_cin = 1'b1; end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    mcand_d     = mcand_q;
    acc_d       = acc_q;
    mq_d        = mq_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    carry_d     = carry_q;
    zero_d      = zero_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;
    mul_sel     = mq_q[0] ? add_sum : acc_q;
    mul_c       = mq_q[0] & add_cout;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          op_d    = op_e'(op);
          mcand_d = a;
          mq_d    = b;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = (op_e'(op) == OpMul) ? StMul : StExec;
        end
      end
      StExec: begin
        result_d = '0;
        carry_d  = 1'b0;
        err_d    = 1'b0;
        unique case (op_q)
          OpNegA, OpNegB, OpAdd, OpSub: begin
            result_d = {{(ProdW-DataW){1'b0}}, add_sum};
            carry_d  = add_cout;
          end
          OpAnd:   result_d = {{(ProdW-DataW){1'b0}}, mcand_q & mq_q};
          OpOr:    result_d = {{(ProdW-DataW){1'b0}}, mcand_q | mq_q};
          default: err_d = 1'b1;
        endcase
        zero_d      = (result_d == '0);
        out_valid_d = 1'b1;
        state_d     = StDone;
      end
      StMul: begin
        acc_d = {mul_c, mul_sel[DataW-1:1]};
        mq_d  = {mul_sel[0], mq_q[DataW-1:1]};
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          result_d    = {acc_d, mq_d};
          carry_d     = 1'b0;
          err_d       = 1'b0;
          zero_d      = (result_d == '0);
          out_valid_d = 1'b1;
          state_d     = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      op_q        <= OpNegA;
      mcand_q     <= '0;
      acc_q       <= '0;
      mq_q        <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      mcand_q     <= mcand_d;
      acc_q       <= acc_d;
      mq_q        <= mq_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      carry_q     <= carry_d;
      zero_q      <= zero_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign carry     = carry_q;
  assign zero      = zero_q;
  assign err       = err_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed-vector bench for alu_seq_ctrl with hand-computed expected results.
module tb_alu_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] op = 3'b000;
  logic [3:0] a = 4'h0;
  logic [3:0] b = 4'h0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] result;
  logic       carry, zero, err, busy;

  int n_vec = 0;
  int n_err = 0;

  alu_seq_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry     (carry),
    .zero      (zero),
    .err       (err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one request, check latency and response, then complete the handshake.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [3:0] xa,
                        input logic [3:0] xb, input logic [7:0] exp_res, input logic exp_c,
                        input logic exp_e, input int exp_lat);
    int lat;
    @(negedge clk);
    in_valid = 1'b1;
    op = o;
    a  = xa;
    b  = xb;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a  = ~xa;
    b  = ~xb;
    op = 3'b100;
    lat = 0;
    while (!out_valid && lat < 20) begin
      check_eq({tag, "_busy"}, {15'd0, busy}, 16'd1);
      check_eq({tag, "_inrdy"}, {15'd0, in_ready}, 16'd0);
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check_eq({tag, "_lat"}, lat[15:0], exp_lat[15:0]);
    check_eq({tag, "_res"}, {8'd0, result}, {8'd0, exp_res});
    check_eq({tag, "_carry"}, {15'd0, carry}, {15'd0, exp_c});
    check_eq({tag, "_zero"}, {15'd0, zero}, {15'd0, exp_res == 8'h00});
    check_eq({tag, "_err"}, {15'd0, err}, {15'd0, exp_e});
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check_eq({tag, "_ovclr"}, {15'd0, out_valid}, 16'd0);
    check_eq({tag, "_idle"}, {15'd0, in_ready}, 16'd1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_eq("rst_inrdy", {15'd0, in_ready}, 16'd1);
    check_eq("rst_busy", {15'd0, busy}, 16'd0);
    check_eq("rst_ov", {15'd0, out_valid}, 16'd0);
    check_eq("rst_res", {8'd0, result}, 16'd0);
    check_eq("rst_flags", {12'd0, carry, zero, err, 1'b0}, 16'd0);

    run_op("add79",   3'b010, 4'd7,  4'd9,  8'h00, 1'b1, 1'b0, 1);
    run_op("sub35",   3'b011, 4'd3,  4'd5,  8'h0E, 1'b0, 1'b0, 1);
    run_op("sub53",   3'b011, 4'd5,  4'd3,  8'h02, 1'b1, 1'b0, 1);
    run_op("addff",   3'b010, 4'hF,  4'hF,  8'h0E, 1'b1, 1'b0, 1);
    run_op("nega3",   3'b000, 4'd3,  4'd9,  8'h0D, 1'b0, 1'b0, 1);
    run_op("nega0",   3'b000, 4'd0,  4'd9,  8'h00, 1'b1, 1'b0, 1);
    run_op("negb1",   3'b001, 4'd6,  4'd1,  8'h0F, 1'b0, 1'b0, 1);
    run_op("and",     3'b100, 4'hC,  4'hA,  8'h08, 1'b0, 1'b0, 1);
    run_op("or",      3'b101, 4'hC,  4'hA,  8'h0E, 1'b0, 1'b0, 1);
    run_op("mulff",   3'b110, 4'hF,  4'hF,  8'hE1, 1'b0, 1'b0, 4);
    run_op("muldb",   3'b110, 4'd13, 4'd11, 8'h8F, 1'b0, 1'b0, 4);
    run_op("mul09",   3'b110, 4'd0,  4'd9,  8'h00, 1'b0, 1'b0, 4);
    run_op("rsvd",    3'b111, 4'd5,  4'd6,  8'h00, 1'b0, 1'b1, 1);

    // Held response under backpressure; in_valid high across the handshake edge.
    @(negedge clk);
    in_valid = 1'b1; op = 3'b110; a = 4'd6; b = 4'd7;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; a = 4'd0; b = 4'd0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_eq("bp_ov", {15'd0, out_valid}, 16'd1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      check_eq("bp_res", {8'd0, result}, 16'h002A);
      check_eq("bp_inrdy", {15'd0, in_ready}, 16'd0);
    end
    in_valid = 1'b1; op = 3'b010; a = 4'd1; b = 4'd1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    check_eq("hs_ov", {15'd0, out_valid}, 16'd0);
    check_eq("hs_noacc", {15'd0, busy}, 16'd0);

    // Abort during the 2nd MUL iteration.
    @(negedge clk);
    in_valid = 1'b1; op = 3'b110; a = 4'd15; b = 4'd15;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_eq("ab_ov", {15'd0, out_valid}, 16'd0);
    check_eq("ab_inrdy", {15'd0, in_ready}, 16'd1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_eq("ab_noresp", {15'd0, out_valid}, 16'd0);
    run_op("add11", 3'b010, 4'd1, 4'd1, 8'h02, 1'b0, 1'b0, 1);

    // Reset wins over an accept on the same edge.
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b1; op = 3'b010;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0;
    check_eq("rst_prio", {15'd0, busy}, 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
